// File: rtl/coord_scan_gen.sv
// -----------------------------------------------------------------------------
// coord_scan_gen
//   Raster coordinate generator for the 2x interpolation datapath. A start
//   pulse in IDLE latches the frame dimensions, and the block then walks every
//   source pixel row-major. For each pixel it presents one beat with the base
//   coordinate, the clamped +1 neighbour and the upscaled destination.
//
// Ports
//   clk, rst_n            : clock; asynchronous active-low reset
//   start                 : frame start request, sampled only in IDLE
//   max_x, max_y          : last column/row index, latched on accepted start
//   out_valid, out_ready  : beat handshake towards pixel fetch
//   x0, y0                : base coordinate
//   x1, y1                : +1 neighbour, clamped to max_x / max_y
//   dst_x, dst_y          : destination coordinate (2*x0, 2*y0)
//   last                  : current beat is the final one of the frame
//   busy                  : frame in progress
//   done                  : one-cycle pulse after the final beat transferred
//   dbg_state             : current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a beat transfers on any rising edge where out_valid and out_ready
// are both high. Once out_valid rises, it and every coordinate output (and
// last) hold unchanged until that transfer happens. out_ready is don't-care
// while out_valid is low.
// -----------------------------------------------------------------------------
module coord_scan_gen #(
    parameter int COORD_W = 8,
    parameter int DST_W   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] max_x,
    input  logic [COORD_W-1:0] max_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] x0,
    output logic [COORD_W-1:0] y0,
    output logic [COORD_W-1:0] x1,
    output logic [COORD_W-1:0] y1,
    output logic [DST_W-1:0]   dst_x,
    output logic [DST_W-1:0]   dst_y,
    output logic               last,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
    logic [COORD_W-1:0] r_max_x, r_max_y;
    logic [DST_W-1:0]   r_dst_x, r_dst_y;
    logic               r_at_end;

    logic [COORD_W-1:0] w_x0_nxt, w_y0_nxt;
    logic [COORD_W-1:0] w_max_x_nxt, w_max_y_nxt;
    logic               w_xfer;
    logic               w_x_end, w_y_end;

    // Compare before incrementing so the +1 never wraps, even at 2^COORD_W-1.
    function automatic logic [COORD_W-1:0] clamp_inc(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] m
    );
        return (v == m) ? v : v + COORD_W'(1);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_x0_nxt    = r_x0;
        w_y0_nxt    = r_y0;
        w_max_x_nxt = r_max_x;
        w_max_y_nxt = r_max_y;
        w_xfer      = (r_state == ST_RUN) && out_ready;
        w_x_end     = (r_x0 == r_max_x);
        w_y_end     = (r_y0 == r_max_y);

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_max_x_nxt = max_x;
                    w_max_y_nxt = max_y;
                    w_x0_nxt    = '0;
                    w_y0_nxt    = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_xfer) begin
                    if (!w_x_end) begin
                        w_x0_nxt = r_x0 + COORD_W'(1);
                    end else if (!w_y_end) begin
                        w_x0_nxt = '0;
                        w_y0_nxt = r_y0 + COORD_W'(1);
                    end else begin
                        // Coordinates hold on the final beat; only state moves.
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Derived outputs are computed from the next coordinate so that they are
    // registered alongside x0/y0 and always agree with them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_max_x  <= '0;
            r_max_y  <= '0;
            r_dst_x  <= '0;
            r_dst_y  <= '0;
            r_at_end <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_x0     <= w_x0_nxt;
            r_y0     <= w_y0_nxt;
            r_max_x  <= w_max_x_nxt;
            r_max_y  <= w_max_y_nxt;
            r_x1     <= clamp_inc(w_x0_nxt, w_max_x_nxt);
            r_y1     <= clamp_inc(w_y0_nxt, w_max_y_nxt);
            r_dst_x  <= DST_W'({w_x0_nxt, 1'b0});
            r_dst_y  <= DST_W'({w_y0_nxt, 1'b0});
            r_at_end <= (w_x0_nxt == w_max_x_nxt) && (w_y0_nxt == w_max_y_nxt);
        end
    end

    assign out_valid = (r_state == ST_RUN);
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign last      = r_at_end && out_valid;
    assign x0        = r_x0;
    assign y0        = r_y0;
    assign x1        = r_x1;
    assign y1        = r_y1;
    assign dst_x     = r_dst_x;
    assign dst_y     = r_dst_y;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_coord_scan_gen.sv
// -----------------------------------------------------------------------------
// tb_coord_scan_gen
//   Scoreboard bench for coord_scan_gen. Frame tasks push the expected beat
//   sequence (computed from the raster rules with plain integer arithmetic)
//   into exp_q; a negedge monitor pops and compares on every transfer, checks
//   stall stability and the done pulse.
// -----------------------------------------------------------------------------
module tb_coord_scan_gen;

    localparam int CW = 8;
    localparam int DW = 9;
    localparam int VW = 4 * CW + 2 * DW + 1;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] max_x = '0;
    logic [CW-1:0] max_y = '0;
    logic          out_valid, last, busy, done;
    logic [CW-1:0] x0, y0, x1, y1;
    logic [DW-1:0] dst_x, dst_y;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    coord_scan_gen #(.COORD_W(CW), .DST_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .max_x     (max_x),
        .max_y     (max_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .dst_x     (dst_x),
        .dst_y     (dst_y),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [VW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_xfer   = 0;
    int            done_cnt = 0;
    int            rdy_mode = 0;
    int            rdy_cnt  = 0;
    logic          exp_done = 1'b0;
    logic          prev_stalled = 1'b0;
    logic [VW-1:0] prev_vec = '0;
    logic [VW-1:0] dut_vec;

    assign dut_vec = {x0, y0, x1, y1, dst_x, dst_y, last};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference beat: neighbour is x+1 unless that passes the last column.
    function automatic logic [VW-1:0] model_beat(input int x, input int y, input int mx, input int my);
        int   nx, ny;
        logic l;
        nx = (x + 1 > mx) ? mx : x + 1;
        ny = (y + 1 > my) ? my : y + 1;
        l  = (x == mx) && (y == my);
        return {CW'(x), CW'(y), CW'(nx), CW'(ny), DW'(2 * x), DW'(2 * y), l};
    endfunction

    task automatic push_frame(input int mx, input int my);
        for (int y = 0; y <= my; y++)
            for (int x = 0; x <= mx; x++)
                exp_q.push_back(model_beat(x, y, mx, my));
    endtask

    // ---------------- out_ready driver ----------------
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            2: begin
                out_ready = (rdy_cnt % 3 == 0);
                rdy_cnt++;
            end
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [VW-1:0] e;
        if (!rst_n) begin
            prev_stalled = 1'b0;
            exp_done     = 1'b0;
        end else begin
            check("done_pulse", done, exp_done);
            if (done) done_cnt++;
            exp_done = 1'b0;
            if (prev_stalled) begin
                check("stall_valid", out_valid, 1);
                check("stall_hold", dut_vec, prev_vec);
            end
            prev_stalled = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat", dut_vec, e);
                        exp_done = e[0];
                        n_xfer++;
                    end
                end else begin
                    prev_stalled = 1'b1;
                    prev_vec     = dut_vec;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame(input int mx, input int my);
        @(posedge clk);
        #1;
        max_x = CW'(mx);
        max_y = CW'(my);
        start = 1'b1;
        push_frame(mx, my);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("first_valid", out_valid, 1);
        check("busy_run", busy, 1);
    endtask

    task automatic wait_done(input int target, input int budget, input bit post);
        int c = 0;
        while (done_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("done_timeout", (done_cnt >= target), 1);
        if (post) begin
            @(negedge clk);
            check("busy_after_done", busy, 0);
            check("valid_after_done", out_valid, 0);
            check("queue_empty", exp_q.size(), 0);
        end
    endtask

    task automatic wait_xfer(input int target, input int budget);
        int c = 0;
        while (n_xfer < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("xfer_timeout", (n_xfer >= target), 1);
    endtask

    // Full-rate frame: count cycles from the first beat to the done pulse.
    task automatic run_timed(input int mx, input int my);
        int d, c, beats;
        d     = done_cnt;
        beats = (mx + 1) * (my + 1);
        start_frame(mx, my);
        c = 0;
        while (done !== 1'b1 && c < beats + 20) begin
            @(negedge clk);
            c++;
        end
        check("frame_cycles", c, beats);
        wait_done(d + 1, 20, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d, b, c, mx, my;
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        check("reset_outs", {out_valid, busy, done, last, x0, y0, x1, y1, dst_x, dst_y}, 0);
        check("reset_state", dbg_state, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_start", out_valid, 0);

        // 3x2 frame at full rate
        run_timed(2, 1);

        // same frame with 1,0,0 ready pattern
        rdy_mode = 2;
        rdy_cnt  = 0;
        d = done_cnt;
        start_frame(2, 1);
        wait_done(d + 1, 100, 1);

        // 1x1 frame
        rdy_mode = 0;
        run_timed(0, 0);

        // full-width single row, exercises x0=255 clamp and dst_x=510
        run_timed(255, 0);

        // start re-pulsed and dimensions changed mid-frame
        rdy_mode = 1;
        b = n_xfer;
        d = done_cnt;
        start_frame(3, 2);
        wait_xfer(b + 4, 100);
        @(posedge clk);
        #1;
        max_x = 8'd7;
        max_y = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        max_x = 8'd1;
        wait_done(d + 1, 200, 1);

        // asynchronous reset in the middle of a frame
        rdy_mode = 0;
        b = n_xfer;
        start_frame(4, 3);
        wait_xfer(b + 2, 50);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outs", {out_valid, busy, done, last, x0, y0, x1, y1, dst_x, dst_y}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_beat_after_reset", out_valid, 0);
        end
        d = done_cnt;
        start_frame(1, 1);
        wait_done(d + 1, 50, 1);

        // start held high: second frame begins right after DONE
        rdy_mode = 1;
        d = done_cnt;
        @(posedge clk);
        #1;
        max_x = 8'd2;
        max_y = 8'd2;
        start = 1'b1;
        push_frame(2, 2);
        push_frame(2, 2);
        wait_done(d + 1, 200, 0);
        c = 0;
        while (busy !== 1'b1 && c < 10) begin
            @(negedge clk);
            c++;
        end
        check("restart_after_done", busy, 1);
        start = 1'b0;
        wait_done(d + 2, 200, 1);
        check("held_start_frames", done_cnt, d + 2);

        // random frames with random back-pressure
        repeat (4) begin
            mx = $urandom_range(0, 9);
            my = $urandom_range(0, 4);
            d  = done_cnt;
            start_frame(mx, my);
            wait_done(d + 1, 8 * (mx + 1) * (my + 1) + 40, 1);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
